// File: rtl/sram_like_resp_pkg.sv
// sram_like_resp_pkg: shared widths, size encodings and byte-lane merge for the SRAM-like responder
package sram_like_resp_pkg;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  typedef enum logic [1:0] {SIZE_B = 2'd0, SIZE_H = 2'd1, SIZE_W = 2'd2} size_e;
  function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                                input logic [SW-1:0] strb);
    merge_lanes = old_w;
    for (int b = 0; b < SW; b++)
      if (strb[b]) merge_lanes[8*b +: 8] = new_w[8*b +: 8];
  endfunction
endpackage

// File: rtl/sram_like_resp_fifo.sv
// resp_fifo: in-order response queue; every entry counts down its own latency, head pops when it hits zero
module resp_fifo
  import sram_like_resp_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          push_wr,
  input  logic [DW-1:0] push_data,
  output logic          full,
  output logic          head_ready,
  output logic          head_wr,
  output logic [DW-1:0] head_data
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam int NW = $clog2(DEPTH + 1);
  logic [CW-1:0] cnt [DEPTH];
  logic          is_wr [DEPTH];
  logic [DW-1:0] data [DEPTH];
  logic [PW-1:0] head, tail;
  logic [NW-1:0] count;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  assign full       = count == NW'(DEPTH);
  assign head_ready = (count != '0) && (cnt[head] == '0);
  assign head_wr    = is_wr[head];
  assign head_data  = data[head];
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= nxt(tail);
      if (head_ready) head <= nxt(head);
      count <= count + NW'(push) - NW'(head_ready);
    end
  end
  // stale slots may keep counting; a push always reloads its slot
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (cnt[i] != '0) cnt[i] <= cnt[i] - CW'(1);
    if (push) begin
      cnt[tail]   <= CW'(LATENCY - 1);
      is_wr[tail] <= push_wr;
      data[tail]  <= push_data;
    end
  end
endmodule

// File: rtl/sram_like_resp.sv
// sram_like_resp: SRAM-like data-side responder with word RAM and fixed-latency in-order responses
module sram_like_resp
  import sram_like_resp_pkg::*;
#(
  parameter int AW      = 12,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          wr,
  input  logic [1:0]    size,
  input  logic [SW-1:0] wstrb,
  input  logic [31:0]   addr,
  input  logic [DW-1:0] wdata,
  output logic          addr_ok,
  output logic          data_ok,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] ram [2**AW];
  logic [AW-1:0] idx;
  logic          accept, full, head_ready, head_wr;
  logic [DW-1:0] head_data;
  logic          unused_bits;
  assign idx         = addr[AW+1:2];
  assign addr_ok     = ~reset & ~full;
  assign accept      = req & addr_ok;
  assign unused_bits = ^{size, addr[31:AW+2], addr[1:0]};
  always_ff @(posedge clk)
    if (accept & wr) ram[idx] <= merge_lanes(ram[idx], wdata, wstrb);
  // reads capture the pre-edge word, so they see earlier writes only
  resp_fifo #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_wr   (wr),
    .push_data (wr ? '0 : ram[idx]),
    .full      (full),
    .head_ready(head_ready),
    .head_wr   (head_wr),
    .head_data (head_data)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      data_ok <= 1'b0;
      rdata   <= '0;
    end else begin
      data_ok <= head_ready;
      if (head_ready) rdata <= head_wr ? '0 : head_data;
    end
  end
endmodule

// File: tb/tb_sram_like_resp.sv
// tb_sram_like_resp: three responder configs on one shared stimulus stream, each with its own reference scoreboard
module tb_sram_like_resp;
  localparam int NI = 3;
  localparam int DS [NI] = '{4, 4, 2};
  localparam int LS [NI] = '{2, 8, 1};
  typedef struct {int due; bit wr; logic [31:0] data;} ent_t;
  logic clk = 0, reset, req, wr;
  logic [1:0] size;
  logic [3:0] wstrb;
  logic [31:0] addr, wdata;
  logic [NI-1:0] aok, dok;
  logic [31:0] rd [NI];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  task automatic check(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  for (genvar i = 0; i < NI; i++) begin : g
    localparam int D = DS[i];
    localparam int L = LS[i];
    ent_t q[$];
    ent_t e;
    logic [31:0] mem [16];
    logic [31:0] rd_m = 0;
    int c = 0;
    bit exp_ok;
    sram_like_resp #(.AW(12), .DEPTH(D), .LATENCY(L)) dut (
      .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
      .addr(addr), .wdata(wdata), .addr_ok(aok[i]), .data_ok(dok[i]), .rdata(rd[i]));
    // reference: a request counts against DEPTH until the edge that raises its response
    always @(posedge clk) begin
      c++;
      if (reset) begin
        q.delete();
        rd_m = 0;
      end else if (req && q.size() < D) begin
        e.due  = c + L;
        e.wr   = wr;
        e.data = wr ? 32'h0 : mem[addr[5:2]];
        if (wr)
          for (int b = 0; b < 4; b++)
            if (wstrb[b]) mem[addr[5:2]][8*b +: 8] = wdata[8*b +: 8];
        q.push_back(e);
      end
    end
    always @(negedge clk) begin
      exp_ok = q.size() > 0 && q[0].due == c;
      check($sformatf("data_ok[%0d]", i), dok[i] === exp_ok, 32'(dok[i]), 32'(exp_ok));
      if (exp_ok) begin
        rd_m = q[0].data;
        void'(q.pop_front());
      end
      check($sformatf("rdata[%0d]", i), rd[i] === rd_m, rd[i], rd_m);
      check($sformatf("addr_ok[%0d]", i), aok[i] === (!reset && q.size() < D),
            32'(aok[i]), 32'(!reset && q.size() < D));
    end
  end
  task automatic drive(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    req = 1; wr = w; addr = a; wstrb = s; wdata = d;
    size = w ? (s == 4'hF ? 2'd2 : 2'd0) : 2'd2;
    @(posedge clk); #2;
  endtask
  task automatic idle(input int n);
    req = 0;
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic issue(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int n = 0;
    req = 0;
    while (aok != '1 && n < 50) begin @(posedge clk); #2; n++; end
    if (n == 50) check("issue_wait", 1'b0, 32'(aok), 32'(3'b111));
    drive(w, a, s, d);
    req = 0;
  endtask
  function automatic logic [31:0] rnd_addr(input int ix);
    return {18'($urandom), 8'h00, 4'(ix), 2'($urandom)};
  endfunction
  initial begin
    req = 0; wr = 0; addr = 0; wdata = 0; wstrb = 0; size = 0; reset = 1;
    @(posedge clk); #2; @(posedge clk); #2;
    reset = 0;
    for (int k = 0; k < 16; k++) issue(1, rnd_addr(k), 4'hF, $urandom);
    issue(1, 32'h10, 4'hF, 32'h11223344);
    issue(1, 32'h8, 4'hF, 32'h0);
    idle(12);
    issue(0, 32'h10, 4'h0, 32'h0);
    idle(12);
    issue(1, 32'h8, 4'b0110, 32'hAABBCCDD);
    issue(0, 32'h8, 4'h0, 32'h0);
    idle(12);
    for (int k = 0; k < 6; k++) drive(0, rnd_addr(k + 3), 4'h0, 32'h0);
    idle(20);
    drive(0, 32'h24, 4'h0, 32'h0);
    drive(1, 32'h24, 4'hF, 32'hFFFFFFFF);
    idle(12);
    issue(0, 32'h24, 4'h0, 32'h0);
    idle(12);
    for (int k = 0; k < 40; k++) drive(0, rnd_addr(k % 16), 4'h0, 32'h0);
    idle(12);
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) < 7) drive($urandom_range(0, 1), rnd_addr($urandom_range(0, 15)), 4'($urandom), $urandom);
      else idle(1);
      reset = 0;
    end
    idle(12);
    drive(1, 32'h30, 4'hF, 32'hCAFEF00D);
    drive(0, 32'h4, 4'h0, 32'h0);
    drive(1, 32'h34, 4'b1001, 32'h12345678);
    req = 0; reset = 1;
    @(posedge clk); #2;
    reset = 0;
    idle(12);
    issue(0, 32'h30, 4'h0, 32'h0);
    issue(0, 32'h34, 4'h0, 32'h0);
    idle(15);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
